// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: two read ports, a debug read port,
// the byte-enabled write port with its ready handshake, and clear control.
interface regfile_param_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
);
  logic [ADDR_W-1:0]   rd_addr_a;
  logic [DATA_W-1:0]   rd_data_a;
  logic [ADDR_W-1:0]   rd_addr_b;
  logic [DATA_W-1:0]   rd_data_b;
  logic [ADDR_W-1:0]   test_addr;
  logic [DATA_W-1:0]   test_data;
  logic                wr_en;
  logic [ADDR_W-1:0]   wr_addr;
  logic [DATA_W/8-1:0] wr_be;
  logic [DATA_W-1:0]   wr_data;
  logic                wr_ready;
  logic                clr_req;
  logic                busy;

  modport master (
    output rd_addr_a, rd_addr_b, test_addr, wr_en, wr_addr, wr_be, wr_data, clr_req,
    input  rd_data_a, rd_data_b, test_data, wr_ready, busy
  );

  modport slave (
    input  rd_addr_a, rd_addr_b, test_addr, wr_en, wr_addr, wr_be, wr_data, clr_req,
    output rd_data_a, rd_data_b, test_data, wr_ready, busy
  );
endinterface

// File: rtl/regfile_param.sv
// Parametrised register file: two optionally bypassed read ports, an unbypassed
// debug read port, byte-enabled writes and a one-entry-per-cycle clear engine.
module regfile_param #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic            clk,
  input  logic            resetn,
  regfile_param_if.slave  bus
);
  localparam int DEPTH = 2 ** ADDR_W;
  localparam int NB    = DATA_W / 8;

  typedef enum logic {CLEAR, IDLE} state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   cnt_q, cnt_d;
  logic [DATA_W-1:0]   mem_q [DEPTH];

  logic                busy;
  logic                wr_acc;
  logic                wr_zero;
  logic [DATA_W-1:0]   wr_merged;
  logic                mem_we;
  logic [ADDR_W-1:0]   mem_waddr;
  logic [DATA_W-1:0]   mem_wdata;

  logic [ADDR_W-1:0]   rd_addr [2];
  logic [DATA_W-1:0]   rd_data [2];

  assign busy         = (state_q == CLEAR);
  assign bus.busy     = busy;
  assign bus.wr_ready = ~busy;
  assign wr_acc       = bus.wr_en & ~busy;
  assign wr_zero      = (ZERO_REG != 0) && (bus.wr_addr == '0);

  // Merged word is shared by the array write and the read-port bypass.
  generate
    for (genvar gi = 0; gi < NB; gi++) begin : g_merge
      assign wr_merged[8*gi +: 8] = bus.wr_be[gi] ? bus.wr_data[8*gi +: 8]
                                                  : mem_q[bus.wr_addr][8*gi +: 8];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == '1) state_d = IDLE;
      end
      IDLE: begin
        if (bus.clr_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      default: state_d = CLEAR;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = bus.wr_addr;
    mem_wdata = wr_merged;
    if (busy) begin
      mem_we    = 1'b1;
      mem_waddr = cnt_q;
      mem_wdata = '0;
    end else if (wr_acc && !wr_zero) begin
      mem_we = 1'b1;
    end
  end

  // No reset on the array so it maps onto distributed RAM; the clear engine zeroes it.
  always_ff @(posedge clk) begin
    if (mem_we) mem_q[mem_waddr] <= mem_wdata;
  end

  assign rd_addr[0]    = bus.rd_addr_a;
  assign rd_addr[1]    = bus.rd_addr_b;
  assign bus.rd_data_a = rd_data[0];
  assign bus.rd_data_b = rd_data[1];

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_rd
      always_comb begin
        rd_data[gi] = mem_q[rd_addr[gi]];
        if ((BYPASS != 0) && wr_acc && (rd_addr[gi] == bus.wr_addr))
          rd_data[gi] = wr_merged;
        if (busy || ((ZERO_REG != 0) && (rd_addr[gi] == '0)))
          rd_data[gi] = '0;
      end
    end
  endgenerate

  always_comb begin
    bus.test_data = mem_q[bus.test_addr];
    if (busy || ((ZERO_REG != 0) && (bus.test_addr == '0)))
      bus.test_data = '0;
  end
endmodule

// File: tb/tb_regfile_param.sv
// Self-checking bench: a bypassed and an unbypassed regfile_param driven in lockstep,
// read-back expectations queued at write time and popped when the read is sampled.
module tb_regfile_param;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int DEPTH = 32;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  logic [AW-1:0] rd_addr_a = '0, rd_addr_b = '0, test_addr = '0, wr_addr = '0;
  logic          wr_en = 1'b0, clr_req = 1'b0;
  logic [3:0]    wr_be = '0;
  logic [DW-1:0] wr_data = '0;

  int n_vec = 0;
  int n_err = 0;
  logic [DW-1:0] exp_q[$];

  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_b ();
  regfile_param_if #(.DATA_W(DW), .ADDR_W(AW)) bus_n ();

  assign bus_b.rd_addr_a = rd_addr_a;  assign bus_n.rd_addr_a = rd_addr_a;
  assign bus_b.rd_addr_b = rd_addr_b;  assign bus_n.rd_addr_b = rd_addr_b;
  assign bus_b.test_addr = test_addr;  assign bus_n.test_addr = test_addr;
  assign bus_b.wr_en     = wr_en;      assign bus_n.wr_en     = wr_en;
  assign bus_b.wr_addr   = wr_addr;    assign bus_n.wr_addr   = wr_addr;
  assign bus_b.wr_be     = wr_be;      assign bus_n.wr_be     = wr_be;
  assign bus_b.wr_data   = wr_data;    assign bus_n.wr_data   = wr_data;
  assign bus_b.clr_req   = clr_req;    assign bus_n.clr_req   = clr_req;

  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(1)) u_byp (
    .clk(clk), .resetn(resetn), .bus(bus_b.slave)
  );
  regfile_param #(.DATA_W(DW), .ADDR_W(AW), .ZERO_REG(1), .BYPASS(0)) u_nob (
    .clk(clk), .resetn(resetn), .bus(bus_n.slave)
  );

  // Counts negedges (hence posedges) seen with busy high, bounded.
  task automatic measure_busy(output int n);
    n = 0;
    while (bus_b.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    int n;
    @(negedge clk);
    resetn = 1'b0;
    #1;
    n_vec++;
    if (bus_b.busy !== 1'b1 || bus_b.wr_ready !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy: busy=%b wr_ready=%b, required busy=1 wr_ready=0", bus_b.busy, bus_b.wr_ready);
    end
    repeat (3) @(negedge clk);
    resetn = 1'b1;
    measure_busy(n);
    n_vec++;
    if (n !== DEPTH) begin
      n_err++;
      $display("FAIL reset_busy_len: got %0d edges, required %0d", n, DEPTH);
    end
    n_vec++;
    if (bus_n.busy !== 1'b0 || bus_b.wr_ready !== 1'b1) begin
      n_err++;
      $display("FAIL reset_idle: nob busy=%b byp wr_ready=%b, required 0/1", bus_n.busy, bus_b.wr_ready);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_a = AW'(a);
      #1;
      n_vec++;
      if (bus_b.rd_data_a !== '0) begin
        n_err++;
        $display("FAIL reset_zero[%0d]: got %h, required 0", a, bus_b.rd_data_a);
      end
    end
  endtask

  task automatic test_byte_enable;
    logic [DW-1:0] got, expv;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 5; wr_data = 32'hDEADBEEF; wr_be = 4'b1111;
    @(negedge clk);
    wr_data = 32'h11223344; wr_be = 4'b0101;
    rd_addr_b = 5; test_addr = 5;
    exp_q.push_back(32'hDE22BE44);   // bypassed port B
    exp_q.push_back(32'hDEADBEEF);   // debug port, stored value
    exp_q.push_back(32'hDEADBEEF);   // unbypassed port B
    #1;
    got = bus_b.rd_data_b; expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL be_bypass_b: got %h, required %h", got, expv); end
    got = bus_b.test_data; expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL be_test_data: got %h, required %h", got, expv); end
    got = bus_n.rd_data_b; expv = exp_q.pop_front(); n_vec++;
    if (got !== expv) begin n_err++; $display("FAIL be_nobypass_b: got %h, required %h", got, expv); end
    // All-zero byte enables: accepted, no change.
    @(negedge clk);
    wr_be = 4'b0000; wr_data = 32'h0;
    #1;
    n_vec++;
    if (bus_b.rd_data_b !== 32'hDE22BE44) begin
      n_err++; $display("FAIL be_zero_bypass: got %h, required DE22BE44", bus_b.rd_data_b);
    end
    @(negedge clk);
    wr_en = 1'b0; rd_addr_a = 5;
    #1;
    n_vec++;
    if (bus_b.rd_data_a !== 32'hDE22BE44 || bus_n.rd_data_a !== 32'hDE22BE44) begin
      n_err++; $display("FAIL be_merged: byp %h nob %h, required DE22BE44", bus_b.rd_data_a, bus_n.rd_data_a);
    end
  endtask

  task automatic test_zero_reg;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 0; wr_data = 32'hFFFFFFFF; wr_be = 4'hF;
    rd_addr_a = 0; rd_addr_b = 0; test_addr = 0;
    for (int c = 0; c < 2; c++) begin
      #1;
      n_vec++;
      if (bus_b.rd_data_a !== '0 || bus_b.rd_data_b !== '0 || bus_b.test_data !== '0 ||
          bus_n.rd_data_a !== '0) begin
        n_err++;
        $display("FAIL zero_reg_c%0d: a=%h b=%h t=%h nob_a=%h, required 0", c,
                 bus_b.rd_data_a, bus_b.rd_data_b, bus_b.test_data, bus_n.rd_data_a);
      end
      @(negedge clk);
      wr_en = 1'b0;
    end
  endtask

  task automatic test_boundary;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = AW'(DEPTH - 1); wr_data = 32'hCAFEF00D; wr_be = 4'hF;
    @(negedge clk);
    wr_en = 1'b0; rd_addr_a = AW'(DEPTH - 1); rd_addr_b = AW'(DEPTH - 1);
    #1;
    n_vec++;
    if (bus_b.rd_data_a !== 32'hCAFEF00D || bus_b.rd_data_b !== 32'hCAFEF00D) begin
      n_err++; $display("FAIL boundary_ab: a=%h b=%h, required CAFEF00D", bus_b.rd_data_a, bus_b.rd_data_b);
    end
  endtask

  task automatic test_fill;
    logic [DW-1:0] expv;
    for (int a = 1; a < DEPTH; a++) begin
      @(negedge clk);
      wr_en = 1'b1; wr_addr = AW'(a); wr_data = DW'(a); wr_be = 4'hF;
      exp_q.push_back(DW'(a));
    end
    @(negedge clk);
    wr_en = 1'b0;
    for (int a = 1; a < DEPTH; a++) begin
      rd_addr_a = AW'(a);
      #1;
      expv = exp_q.pop_front();
      n_vec++;
      if (bus_b.rd_data_a !== expv || bus_n.rd_data_a !== expv) begin
        n_err++; $display("FAIL fill[%0d]: byp %h nob %h, required %h", a, bus_b.rd_data_a, bus_n.rd_data_a, expv);
      end
    end
  endtask

  task automatic test_clear;
    int n;
    @(negedge clk);
    clr_req = 1'b1; wr_en = 1'b1; wr_addr = 7; wr_data = 32'hAAAA0000; wr_be = 4'hF;
    rd_addr_b = 7;
    #1;
    n_vec++;
    if (bus_b.rd_data_b !== 32'hAAAA0000 || bus_n.rd_data_b !== 32'h7) begin
      n_err++; $display("FAIL clr_same_edge: byp %h nob %h, required AAAA0000/00000007", bus_b.rd_data_b, bus_n.rd_data_b);
    end
    @(negedge clk);
    clr_req = 1'b0; wr_addr = 9; wr_data = 32'h55555555;
    n = 0;
    while (bus_b.busy === 1'b1 && n < 200) begin
      n++;
      clr_req = (n == 10);
      if (n == 3) begin
        rd_addr_a = AW'(DEPTH - 1); test_addr = AW'(DEPTH - 1);
        #1;
        n_vec++;
        if (bus_b.rd_data_a !== '0 || bus_b.test_data !== '0 || bus_b.wr_ready !== 1'b0) begin
          n_err++; $display("FAIL clr_mask: a=%h t=%h wr_ready=%b, required 0/0/0", bus_b.rd_data_a, bus_b.test_data, bus_b.wr_ready);
        end
      end
      @(negedge clk);
    end
    wr_en = 1'b0; clr_req = 1'b0;
    n_vec++;
    if (n !== DEPTH) begin
      n_err++; $display("FAIL clr_busy_len: got %0d edges, required %0d", n, DEPTH);
    end
    for (int a = 0; a < DEPTH; a++) begin
      rd_addr_a = AW'(a); test_addr = AW'(a);
      #1;
      n_vec++;
      if (bus_b.rd_data_a !== '0 || bus_b.test_data !== '0 || bus_n.rd_data_a !== '0) begin
        n_err++; $display("FAIL clr_zero[%0d]: a=%h t=%h nob=%h, required 0", a, bus_b.rd_data_a, bus_b.test_data, bus_n.rd_data_a);
      end
    end
  endtask

  task automatic test_reset_abort;
    int n;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 20; wr_data = 32'h00001234; wr_be = 4'hF;
    @(negedge clk);
    wr_en = 1'b0; clr_req = 1'b1;
    @(negedge clk);
    clr_req = 1'b0;
    repeat (10) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_vec++;
    if (bus_b.busy !== 1'b1 || bus_b.wr_ready !== 1'b0) begin
      n_err++; $display("FAIL abort_busy: busy=%b wr_ready=%b, required 1/0", bus_b.busy, bus_b.wr_ready);
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    measure_busy(n);
    n_vec++;
    if (n !== DEPTH) begin
      n_err++; $display("FAIL abort_busy_len: got %0d edges, required %0d", n, DEPTH);
    end
    rd_addr_a = 20;
    #1;
    n_vec++;
    if (bus_b.rd_data_a !== '0) begin
      n_err++; $display("FAIL abort_zero: got %h, required 0", bus_b.rd_data_a);
    end
  endtask

  task automatic test_no_bypass;
    @(negedge clk);
    wr_en = 1'b1; wr_addr = 3; wr_data = 32'h12345678; wr_be = 4'hF; rd_addr_a = 3;
    #1;
    n_vec++;
    if (bus_n.rd_data_a !== 32'h0 || bus_b.rd_data_a !== 32'h12345678) begin
      n_err++; $display("FAIL nobyp_write_cycle: nob %h byp %h, required 00000000/12345678", bus_n.rd_data_a, bus_b.rd_data_a);
    end
    @(negedge clk);
    wr_en = 1'b0;
    #1;
    n_vec++;
    if (bus_n.rd_data_a !== 32'h12345678) begin
      n_err++; $display("FAIL nobyp_next_cycle: got %h, required 12345678", bus_n.rd_data_a);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_byte_enable();
    test_zero_reg();
    test_boundary();
    test_fill();
    test_clear();
    test_reset_abort();
    test_no_bypass();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
